// File: rtl/phaser_ref_lock_ctrl.sv
//----------------------------------------------------------------------------
// phaser_ref_lock_ctrl
//
// Bring-up and lock-supervision controller for the phaser reference-clock
// block. Sequences power-down release, a timed reset pulse, the wait for
// LOCKED and a lock-stability qualification window before raising READY.
// Lock loss or lock timeout triggers a bounded number of retries, after
// which the controller parks in FAIL until ENABLE is dropped.
//
// Ports:
//   CLK         controller clock (independent of the phaser CLKIN)
//   RST_N       asynchronous active-low reset
//   ENABLE      level request to run the phaser reference
//   LOCKED_IN   LOCKED from the phaser reference
//   PHY_PWRDWN  drives phaser PWRDWN
//   PHY_RST     drives phaser RST
//   READY       lock qualified and stable
//   FAIL        retry budget exhausted
//   LOST_LOCK   one-cycle pulse when lock drops while READY
//   RETRY_CNT   retries since leaving IDLE (saturates at MAX_RETRY)
//   STATE       current state encoding (debug)
//
// Build option:
//   PHASER_REF_CTRL_SYNC_EN  when defined, LOCKED_IN passes through a
//                            2-flop synchronizer (adds 2 cycles of lock
//                            latency). When undefined, LOCKED_IN must
//                            already be synchronous to CLK.
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module phaser_ref_lock_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 8,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 13
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENABLE,
  input  logic       LOCKED_IN,
  output logic       PHY_PWRDWN,
  output logic       PHY_RST,
  output logic       READY,
  output logic       FAIL,
  output logic       LOST_LOCK,
  output logic [3:0] RETRY_CNT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_READY     = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  // Terminal counts: every phase ends on its compare, so cnt never wraps.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

  state_t           state_r;
  state_t           state_nx_s;
  state_t           retry_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic [3:0]       retry_r;
  logic [3:0]       retry_nx_s;
  logic [3:0]       retry_inc_s;
  logic             lost_nx_s;
  logic             lock_s;
  logic             pwrdwn_r;
  logic             phy_rst_r;
  logic             ready_r;
  logic             fail_r;
  logic             lost_r;

  // Output decode {PWRDWN, RST, READY, FAIL}; unknown codes take the
  // safe powered-down pattern.
  function automatic logic [3:0] decode_out(input state_t st);
    logic [3:0] res;
    case (st)
      ST_IDLE:      res = 4'b1100;
      ST_RESET:     res = 4'b0100;
      ST_WAIT_LOCK: res = 4'b0000;
      ST_STABLE:    res = 4'b0000;
      ST_READY:     res = 4'b0010;
      ST_FAIL:      res = 4'b1101;
      default:      res = 4'b1100;
    endcase
    return res;
  endfunction

`ifdef PHASER_REF_CTRL_SYNC_EN
  logic sync_q1_r;
  logic sync_q2_r;

  // Two-flop synchronizer bringing LOCKED_IN into the CLK domain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q1_r <= 1'b0;
      sync_q2_r <= 1'b0;
    end else begin
      sync_q1_r <= LOCKED_IN;
      sync_q2_r <= sync_q1_r;
    end
  end

  assign lock_s = sync_q2_r;
`else
  assign lock_s = LOCKED_IN;
`endif

  // Outcome of a retry: FAIL once the budget is spent, else re-run reset.
  always_comb begin
    retry_state_s = ST_RESET;
    retry_inc_s   = retry_r;
    if (retry_r == RETRY_MAX) begin
      retry_state_s = ST_FAIL;
      retry_inc_s   = retry_r;
    end else begin
      retry_state_s = ST_RESET;
      retry_inc_s   = retry_r + 4'd1;
    end
  end

  // Next-state, phase counter, retry counter and lost-lock pulse.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    retry_nx_s = retry_r;
    lost_nx_s  = 1'b0;
    if (!ENABLE) begin
      // Dropping ENABLE overrides everything, including a pending lost-lock.
      state_nx_s = ST_IDLE;
      cnt_nx_s   = '0;
      retry_nx_s = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_RESET;
          cnt_nx_s   = '0;
          retry_nx_s = 4'd0;
        end
        ST_RESET: begin
          if (cnt_r == RST_LAST) begin
            state_nx_s = ST_WAIT_LOCK;
            cnt_nx_s   = '0;
          end else begin
            cnt_nx_s   = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock seen on the timeout cycle still wins over the retry.
          if (lock_s) begin
            state_nx_s = ST_STABLE;
            cnt_nx_s   = '0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_nx_s = retry_state_s;
            retry_nx_s = retry_inc_s;
            cnt_nx_s   = '0;
          end else begin
            cnt_nx_s   = cnt_r + CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_nx_s = retry_state_s;
            retry_nx_s = retry_inc_s;
            cnt_nx_s   = '0;
          end else if (cnt_r == STABLE_LAST) begin
            state_nx_s = ST_READY;
            cnt_nx_s   = '0;
          end else begin
            cnt_nx_s   = cnt_r + CNT_ONE;
          end
        end
        ST_READY: begin
          if (!lock_s) begin
            lost_nx_s  = 1'b1;
            state_nx_s = retry_state_s;
            retry_nx_s = retry_inc_s;
            cnt_nx_s   = '0;
          end else begin
            state_nx_s = ST_READY;
            cnt_nx_s   = '0;
          end
        end
        ST_FAIL: begin
          state_nx_s = ST_FAIL;
          cnt_nx_s   = '0;
        end
        default: begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = '0;
          retry_nx_s = 4'd0;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs are decoded from the next state
  // so they are registered yet aligned with STATE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      retry_r   <= 4'd0;
      pwrdwn_r  <= 1'b1;
      phy_rst_r <= 1'b1;
      ready_r   <= 1'b0;
      fail_r    <= 1'b0;
      lost_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      retry_r   <= retry_nx_s;
      {pwrdwn_r, phy_rst_r, ready_r, fail_r} <= decode_out(state_nx_s);
      lost_r    <= lost_nx_s;
    end
  end

  assign PHY_PWRDWN = pwrdwn_r;
  assign PHY_RST    = phy_rst_r;
  assign READY      = ready_r;
  assign FAIL       = fail_r;
  assign LOST_LOCK  = lost_r;
  assign RETRY_CNT  = retry_r;
  assign STATE      = state_r;

endmodule

// File: tb/tb_phaser_ref_lock_ctrl.sv
`timescale 1ns/1ps

module tb_phaser_ref_lock_ctrl;

  localparam int RST_C = 16;
  localparam int TO    = 128;
  localparam int STB   = 8;
  localparam int MAXR  = 3;
`ifdef PHASER_REF_CTRL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam logic [11:0] RESET_VEC = {3'd0, 4'd0, 1'b0, 4'b1100};

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       ENABLE;
  logic       LOCKED_IN;
  logic       PHY_PWRDWN;
  logic       PHY_RST;
  logic       READY;
  logic       FAIL;
  logic       LOST_LOCK;
  logic [3:0] RETRY_CNT;
  logic [2:0] STATE;

  phaser_ref_lock_ctrl #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TO),
    .STABLE_CYCLES(STB),
    .MAX_RETRY    (MAXR),
    .CNT_W        (13)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ENABLE    (ENABLE),
    .LOCKED_IN (LOCKED_IN),
    .PHY_PWRDWN(PHY_PWRDWN),
    .PHY_RST   (PHY_RST),
    .READY     (READY),
    .FAIL      (FAIL),
    .LOST_LOCK (LOST_LOCK),
    .RETRY_CNT (RETRY_CNT),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [3:0] retry;
    logic       lost;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Output table {PWRDWN, RST, READY, FAIL} for a given state code.
  function automatic logic [3:0] out_of(input logic [2:0] st);
    case (st)
      3'd0:    return 4'b1100;
      3'd1:    return 4'b0100;
      3'd2:    return 4'b0000;
      3'd3:    return 4'b0000;
      3'd4:    return 4'b0010;
      3'd5:    return 4'b1101;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic logic [11:0] snap();
    return {STATE, RETRY_CNT, LOST_LOCK, PHY_PWRDWN, PHY_RST, READY, FAIL};
  endfunction

  task automatic push(input int c, input logic [2:0] st, input logic [3:0] r, input logic lost);
    exp_t e;
    e.cyc = c; e.st = st; e.retry = r; e.lost = lost;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%b required=%b", name, act, req);
  endtask

  // Monitor: every state change or LOST_LOCK pulse is an output event and
  // must match the next expected event, including the cycle it occurs on.
  logic [2:0] prev_st = 3'd0;
  always @(negedge CLK) begin
    if (STATE !== prev_st || LOST_LOCK !== 1'b0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event cyc=%0d actual=%b required=none", cyc, snap());
      end else begin
        mon_e = exp_q.pop_front();
        if (snap() === {mon_e.st, mon_e.retry, mon_e.lost, out_of(mon_e.st)} && cyc == mon_e.cyc)
          n_pass++;
        else
          $display("FAIL event actual=cyc%0d/%b required=cyc%0d/%b", cyc, snap(),
                   mon_e.cyc, {mon_e.st, mon_e.retry, mon_e.lost, out_of(mon_e.st)});
      end
    end
    prev_st = STATE;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int c, c0, w, s, t, f, a, b, d;

  initial begin
    RST_N = 1'b0; ENABLE = 1'b0; LOCKED_IN = 1'b0;
    goto(2);
    chk("reset_values", snap(), RESET_VEC);
    RST_N = 1'b1;
    goto(4);

    // Nominal bring-up; lock 100 cycles after PHY_RST falls.
    c0 = cyc; ENABLE = 1'b1;
    push(c0 + 1, 3'd1, 4'd0, 1'b0);
    push(c0 + 17, 3'd2, 4'd0, 1'b0);
    goto(c0 + 117); LOCKED_IN = 1'b1;
    push(c0 + 117 + LAT, 3'd3, 4'd0, 1'b0);
    push(c0 + 117 + LAT + 8, 3'd4, 4'd0, 1'b0);
    goto(c0 + 117 + LAT + 13);

    // One-cycle lock drop while READY, then relock.
    c = cyc; LOCKED_IN = 1'b0;
    push(c + LAT, 3'd1, 4'd1, 1'b1);
    push(c + LAT + 16, 3'd2, 4'd1, 1'b0);
    push(c + LAT + 17, 3'd3, 4'd1, 1'b0);
    push(c + LAT + 25, 3'd4, 4'd1, 1'b0);
    goto(c + 1); LOCKED_IN = 1'b1;
    goto(c + LAT + 30);

    // Long drop, then lock only 5 cycles during STABLE.
    c = cyc; LOCKED_IN = 1'b0;
    push(c + LAT, 3'd1, 4'd2, 1'b1);
    push(c + LAT + 16, 3'd2, 4'd2, 1'b0);
    w = c + LAT + 16;
    goto(w); LOCKED_IN = 1'b1;
    push(w + LAT, 3'd3, 4'd2, 1'b0);
    goto(w + 5); LOCKED_IN = 1'b0; s = w + 5;
    push(s + LAT, 3'd1, 4'd3, 1'b0);
    push(s + LAT + 16, 3'd2, 4'd3, 1'b0);

    // Lock arrives exactly on the timeout cycle with the budget spent.
    t = s + LAT + 16;
    push(t + TO, 3'd3, 4'd3, 1'b0);
    push(t + TO + 8, 3'd4, 4'd3, 1'b0);
    goto(t + TO - LAT); LOCKED_IN = 1'b1;
    goto(t + TO + 12);

    // ENABLE=0 while READY.
    c = cyc; ENABLE = 1'b0;
    push(c + 1, 3'd0, 4'd0, 1'b0);
    goto(c + 3);

    // Lock never arrives: 4 reset/wait rounds then FAIL.
    LOCKED_IN = 1'b0; c = cyc; ENABLE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(c + 1 + 144 * k, 3'd1, 4'(k), 1'b0);
      push(c + 17 + 144 * k, 3'd2, 4'(k), 1'b0);
    end
    push(c + 577, 3'd5, 4'd3, 1'b0);
    goto(c + 585);
    f = cyc; ENABLE = 1'b0;
    push(f + 1, 3'd0, 4'd0, 1'b0);
    goto(f + 3);

    // ENABLE=0 during RESET.
    a = cyc; ENABLE = 1'b1;
    push(a + 1, 3'd1, 4'd0, 1'b0);
    goto(a + 5); ENABLE = 1'b0;
    push(a + 6, 3'd0, 4'd0, 1'b0);
    goto(a + 8);

    // ENABLE=0 during WAIT_LOCK.
    b = cyc; ENABLE = 1'b1;
    push(b + 1, 3'd1, 4'd0, 1'b0);
    push(b + 17, 3'd2, 4'd0, 1'b0);
    goto(b + 30); ENABLE = 1'b0;
    push(b + 31, 3'd0, 4'd0, 1'b0);
    goto(b + 33);

    // Asynchronous reset mid WAIT_LOCK.
    d = cyc; ENABLE = 1'b1;
    push(d + 1, 3'd1, 4'd0, 1'b0);
    push(d + 17, 3'd2, 4'd0, 1'b0);
    goto(d + 40);
    push(d + 40, 3'd0, 4'd0, 1'b0);
    RST_N = 1'b0;
    #1;
    chk("async_reset", snap(), RESET_VEC);
    ENABLE = 1'b0;
    goto(d + 43); RST_N = 1'b1;
    goto(d + 48);

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL pending_events actual=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
